// File: rtl/ve370_mem_pkg.sv
// Shared definitions for the data/instruction memory responders: FSM encoding,
// word geometry, response record layout and the access-error rule.
package ve370_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_e;

   localparam int unsigned WORD_BYTES = 4;
   localparam logic [1:0]  ALIGN_MASK = 2'b11;

   // Response record field widths, shared with the instruction-side responder.
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              error;
   } mem_resp_t;

   // Misaligned byte address or word index beyond the array.
   function automatic logic addr_error(input logic [ADDR_W-1:0] addr,
                                       input int unsigned       depth_words);
      logic [ADDR_W-1:0] w_word_idx;
      w_word_idx = {2'b00, addr[ADDR_W-1:2]};
      return ((addr[1:0] & ALIGN_MASK) != 2'b00) || (w_word_idx >= depth_words);
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word array: synchronous write, combinational read. No reset, so
// contents survive a responder reset.
module mem_word_array
   import ve370_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
   input  logic              clock,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

   // Store path: one word per enabled edge.
   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_idx] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_memory_responder.sv
// Fixed-latency data memory responder with valid/ready request and response
// channels. One request in flight; the array is touched on the edge entering RESP.
module data_memory_responder
   import ve370_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned LATENCY     = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_error
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
      $error("data_memory_responder: LATENCY must be within 1..15");
   end

   mem_state_e        r_state, w_state_d;
   logic [CNT_W-1:0]  r_cnt, w_cnt_d;
   logic              r_write, w_write_d;
   logic [ADDR_W-1:0] r_addr, w_addr_d;
   logic [DATA_W-1:0] r_wdata, w_wdata_d;
   mem_resp_t         r_resp, w_resp_d;

   logic              w_accept;
   logic              w_enter_resp;
   logic              w_acc_write;
   logic [ADDR_W-1:0] w_acc_addr;
   logic [DATA_W-1:0] w_acc_wdata;
   logic              w_acc_err;
   logic              w_mem_we;
   logic [DATA_W-1:0] w_mem_rdata;

   assign w_accept = req_valid && (r_state == IDLE);

   // With LATENCY==1 the access happens on the accept edge, so use the live
   // request; otherwise use the latched copy.
   assign w_acc_write = (r_state == IDLE) ? req_write : r_write;
   assign w_acc_addr  = (r_state == IDLE) ? req_addr  : r_addr;
   assign w_acc_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
   assign w_acc_err   = addr_error(w_acc_addr, DEPTH_WORDS);
   assign w_mem_we    = w_enter_resp && w_acc_write && !w_acc_err;

   mem_word_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clock   (clock),
      .i_we    (w_mem_we),
      .i_idx   (w_acc_addr[IDX_W+1:2]),
      .i_wdata (w_acc_wdata),
      .o_rdata (w_mem_rdata)
   );

   // Next-state, latency counter, request latch and response capture.
   always_comb begin
      w_state_d    = r_state;
      w_cnt_d      = r_cnt;
      w_write_d    = r_write;
      w_addr_d     = r_addr;
      w_wdata_d    = r_wdata;
      w_resp_d     = r_resp;
      w_enter_resp = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_write_d = req_write;
               w_addr_d  = req_addr;
               w_wdata_d = req_wdata;
               if (LATENCY == 1) begin
                  w_state_d    = RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  w_state_d = WAIT;
                  w_cnt_d   = CNT_W'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            w_cnt_d = r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
               w_state_d    = RESP;
               w_enter_resp = 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               w_state_d = IDLE;
               w_resp_d  = '0;
            end
         end
         default: begin
            w_state_d = IDLE;
         end
      endcase

      if (w_enter_resp) begin
         w_resp_d.error = w_acc_err;
         w_resp_d.rdata = (!w_acc_err && !w_acc_write) ? w_mem_rdata : '0;
      end
   end

   // State and datapath registers; reset drops any pending request or response.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_resp  <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_write <= w_write_d;
         r_addr  <= w_addr_d;
         r_wdata <= w_wdata_d;
         r_resp  <= w_resp_d;
      end
   end

   assign req_ready  = (r_state == IDLE);
   assign resp_valid = (r_state == RESP);
   assign resp_rdata = r_resp.rdata;
   assign resp_error = r_resp.error;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: three builds (LATENCY 2, 1, 15)
// share clock and reset; expectations come from a per-build memory model and
// a response scoreboard.
module tb_data_memory_responder;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req_valid  [3];
   logic        req_write  [3];
   logic [31:0] req_addr   [3];
   logic [31:0] req_wdata  [3];
   logic        req_ready  [3];
   logic        resp_valid [3];
   logic        resp_ready [3];
   logic [31:0] resp_rdata [3];
   logic        resp_error [3];

   exp_t        sb [$];
   logic [31:0] mdl [3][64];
   time         t_prev [3];
   bit          have_prev [3];
   int          checks;
   int          errors;

   always #5 clock = ~clock;

   data_memory_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut_l2 (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid[0]), .req_write(req_write[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .req_ready(req_ready[0]), .resp_valid(resp_valid[0]),
      .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0])
   );

   data_memory_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_dut_l1 (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid[1]), .req_write(req_write[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .req_ready(req_ready[1]), .resp_valid(resp_valid[1]),
      .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1])
   );

   data_memory_responder #(.DEPTH_WORDS(64), .LATENCY(15)) u_dut_l15 (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid[2]), .req_write(req_write[2]), .req_addr(req_addr[2]),
      .req_wdata(req_wdata[2]), .req_ready(req_ready[2]), .resp_valid(resp_valid[2]),
      .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]), .resp_error(resp_error[2])
   );

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full transaction on build k; bp = cycles of held-off resp_ready.
   task automatic do_req(input int k, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input int bp, input bit b2b);
      exp_t e;
      int   n;
      bit   err;
      bit   got;
      err     = (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
      e.err   = err;
      e.rdata = 32'h0;
      if (!err) begin
         if (w) mdl[k][a[7:2]] = d;
         else   e.rdata = mdl[k][a[7:2]];
      end
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (req_ready[k]) begin
            got = 1'b1;
            break;
         end
         @(posedge clock); #1;
      end
      if (!got) chk("ready_timeout", {31'b0, req_ready[k]}, 32'd1);
      req_valid[k]  = 1'b1;
      req_write[k]  = w;
      req_addr[k]   = a;
      req_wdata[k]  = d;
      resp_ready[k] = (bp == 0);
      sb.push_back(e);
      @(posedge clock);
      if (b2b && have_prev[k]) chk("period", 32'(($time - t_prev[k]) / 10), 32'(lat_of(k) + 1));
      t_prev[k]    = $time;
      have_prev[k] = 1'b1;
      #1;
      // Scramble the request bus to prove the responder latched it.
      req_valid[k] = 1'b0;
      req_write[k] = 1'($urandom);
      req_addr[k]  = $urandom;
      req_wdata[k] = $urandom;
      n   = 1;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (resp_valid[k]) begin
            got = 1'b1;
            break;
         end
         chk("req_ready_wait", {31'b0, req_ready[k]}, 32'd0);
         @(posedge clock); #1;
         n++;
      end
      if (!got) chk("resp_timeout", {31'b0, resp_valid[k]}, 32'd1);
      chk("latency", 32'(n), 32'(lat_of(k)));
      e = sb[0];
      for (int i = 0; i < bp; i++) begin
         chk("bp_valid", {31'b0, resp_valid[k]}, 32'd1);
         chk("bp_rdata", resp_rdata[k], e.rdata);
         chk("bp_error", {31'b0, resp_error[k]}, {31'b0, e.err});
         chk("bp_req_ready", {31'b0, req_ready[k]}, 32'd0);
         @(posedge clock); #1;
      end
      resp_ready[k] = 1'b1;
      e = sb.pop_front();
      chk("resp_valid", {31'b0, resp_valid[k]}, 32'd1);
      chk("resp_rdata", resp_rdata[k], e.rdata);
      chk("resp_error", {31'b0, resp_error[k]}, {31'b0, e.err});
      @(posedge clock); #1;
      resp_ready[k] = 1'b0;
      chk("req_ready_after", {31'b0, req_ready[k]}, 32'd1);
      chk("valid_after", {31'b0, resp_valid[k]}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_valid[i]  = 1'b0;
         req_write[i]  = 1'b0;
         req_addr[i]   = 32'h0;
         req_wdata[i]  = 32'h0;
         resp_ready[i] = 1'b0;
         have_prev[i]  = 1'b0;
         t_prev[i]     = 0;
      end
      #12;
      chk("rst_req_ready", {31'b0, req_ready[0]}, 32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid[0]}, 32'd0);
      chk("rst_resp_rdata", resp_rdata[0], 32'h0);
      chk("rst_resp_error", {31'b0, resp_error[0]}, 32'd0);
      @(negedge clock) reset_n = 1'b1;
      @(posedge clock); #1;

      // Store/load, boundaries and errors on the LATENCY=2 build.
      do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
      do_req(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);
      do_req(0, 1'b1, 32'hFC, 32'hCAFEF00D, 0, 1'b0);
      do_req(0, 1'b1, 32'h0, 32'h0BADCAFE, 0, 1'b0);
      do_req(0, 1'b0, 32'h0, 32'h0, 0, 1'b0);
      do_req(0, 1'b0, 32'h11, 32'h0, 0, 1'b0);
      do_req(0, 1'b1, 32'h100, 32'h55555555, 0, 1'b0);
      do_req(0, 1'b0, 32'hFC, 32'h0, 0, 1'b0);
      do_req(0, 1'b0, 32'h10, 32'h0, 5, 1'b0);
      do_req(0, 1'b1, 32'h20, 32'hA5A50001, 0, 1'b0);

      // Reset while a store is in WAIT: the store must be lost.
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h20;
      req_wdata[0] = 32'h12345678;
      @(posedge clock); #1;
      req_valid[0] = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("wait_rst_req_ready", {31'b0, req_ready[0]}, 32'd1);
      chk("wait_rst_resp_valid", {31'b0, resp_valid[0]}, 32'd0);
      @(negedge clock) reset_n = 1'b1;
      @(posedge clock); #1;
      do_req(0, 1'b0, 32'h20, 32'h0, 0, 1'b0);

      // Reset mid-cycle while a response is pending: outputs clear at once.
      req_valid[0]  = 1'b1;
      req_write[0]  = 1'b0;
      req_addr[0]   = 32'h10;
      resp_ready[0] = 1'b0;
      @(posedge clock); #1;
      req_valid[0] = 1'b0;
      @(posedge clock); #1;
      chk("pre_rst_valid", {31'b0, resp_valid[0]}, 32'd1);
      chk("pre_rst_rdata", resp_rdata[0], 32'hDEADBEEF);
      #3 reset_n = 1'b0;
      #1;
      chk("resp_rst_req_ready", {31'b0, req_ready[0]}, 32'd1);
      chk("resp_rst_resp_valid", {31'b0, resp_valid[0]}, 32'd0);
      chk("resp_rst_resp_rdata", resp_rdata[0], 32'h0);
      chk("resp_rst_resp_error", {31'b0, resp_error[0]}, 32'd0);
      @(negedge clock) reset_n = 1'b1;
      @(posedge clock); #1;
      chk("post_rst_valid", {31'b0, resp_valid[0]}, 32'd0);

      // Back-to-back traffic on the LATENCY=1 and LATENCY=15 builds.
      for (int k = 1; k < 3; k++) begin
         do_req(k, 1'b1, 32'h4, 32'h11111111, 0, 1'b1);
         do_req(k, 1'b1, 32'h8, 32'h22222222, 0, 1'b1);
         do_req(k, 1'b0, 32'h4, 32'h0, 0, 1'b1);
         do_req(k, 1'b0, 32'h8, 32'h0, 0, 1'b1);
         do_req(k, 1'b0, 32'hFE, 32'h0, 0, 1'b1);
         do_req(k, 1'b0, 32'h4, 32'h0, 0, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
